sha256_seq_ctrl: RTL and testbench
==================================

# sha256_seq_ctrl

Message-block sequencer for the iterative `sha256` core. It accepts 512-bit padded message blocks over a valid/ready handshake and selects the chaining value for each block: the standard IV for a first block, the previous result otherwise. It launches the core, waits for completion, and presents the final 256-bit digest over a valid/ready handshake. It sits between the message padder/buffer and the `sha256` core, and sequences the SHA-256 stage of the Hash160 pipeline.

## Interface
- `TIMEOUT`, default 96: maximum number of cycles from core launch to `core_output_valid` before the block is aborted.
- `clk` in 1: the single clock; everything is registered on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `blk_valid` in 1: the upstream block is valid.
- `blk_ready` out 1: the controller can accept a block.
- `blk_data` in 512: padded message block, word 0 in bits [511:480].
- `blk_first` in 1: this block starts a new message.
- `blk_last` in 1: this block ends the message.
- `core_H_in` out 256: chaining value driven to the core.
- `core_M_in` out 512: message block driven to the core.
- `core_input_valid` out 1: one-cycle launch pulse to the core.
- `core_H_out` in 256: result from the core.
- `core_output_valid` in 1: the core result is valid this cycle.
- `digest` out 256: final hash.
- `dig_valid` out 1: `digest` is valid.
- `dig_ready` in 1: downstream accepts `digest`.
- `busy` out 1: high in every state except IDLE.
- `err_timeout` out 1: sticky; cleared on the next accepted `blk_first` block.
- `blk_count` out 8: blocks completed in the current message; wraps modulo 256.

## Operation
- States: IDLE, LAUNCH, RUN, DONE.
- IDLE
  - `blk_ready`=1.
  - On `blk_valid`&&`blk_ready`: latch `blk_data` into `m_reg` and `blk_last` into `last_reg`.
  - `h_sel_reg` = IV if `blk_first`==1 or `chain_open`==0; otherwise `chain_reg`.
  - IV = 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
  - Go to LAUNCH.
- LAUNCH
  - `core_input_valid`=1 for exactly one cycle.
  - Clear the timeout counter.
  - Go to RUN.
- RUN
  - The timeout counter increments each cycle.
  - On `core_output_valid`: `chain_reg` <= `core_H_out`; `blk_count`++.
    - If `last_reg`: `digest` <= `core_H_out`, `chain_open` <= 0, go to DONE.
    - Otherwise: `chain_open` <= 1, go to IDLE.
  - If the counter reaches `TIMEOUT` with no `core_output_valid`: set `err_timeout`, `chain_open` <= 0, `blk_count` <= 0, go to IDLE.
- DONE
  - `dig_valid`=1 and `digest` held stable.
  - On `dig_ready`: go to IDLE and clear `blk_count` to 0.
- `core_H_in`/`core_M_in` are driven from `h_sel_reg`/`m_reg`. They must stay constant from LAUNCH until RUN exits, because the core adds `H_in` into its result every cycle.
- `core_output_valid` outside RUN is ignored (this covers spurious or late pulses from a 9-bit round wrap).
- A `blk_first` arriving while a chain is open restarts from IV; the partial chain is discarded.
- Width rules: no arithmetic in this block except the counters. The timeout counter is 8 bits and saturates at `TIMEOUT`.

## Timing
- Reset values:
  - State IDLE.
  - `blk_ready`=1 while `rst_n` is high in IDLE.
  - `core_input_valid`=0, `dig_valid`=0, `busy`=0, `err_timeout`=0, `blk_count`=0, `chain_open`=0.
  - `digest`, `core_H_in` and `core_M_in` are all 0.
- Block accepted at cycle T: `core_input_valid` is high in cycle T+1, and RUN starts at T+2.
- With the `sha256` core, `core_output_valid` arrives about 66 cycles after launch. `dig_valid` rises the cycle after `core_output_valid` is sampled.
- Per-block throughput: 1 (accept) + 1 (launch) + core latency. For a non-last block, `blk_ready` returns high the cycle after completion.
- `dig_valid` and `digest` are held while `dig_ready`=0. A handshake completes the cycle both are high.
- Reset asserted mid-RUN: all state is cleared immediately and the in-flight block is lost. The core is not relaunched until a new block is accepted.
- `blk_ready` is combinational only on state, never on `blk_valid`.

## Test plan
- Single block "abc" (padded; `first`=`last`=1), `dig_ready`=1 -> `digest` = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad; `blk_count`=1 before it clears; exactly one `core_input_valid` pulse.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq" -> block 2 launches with `core_H_in` equal to block 1's `core_H_out`; `digest` = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Backpressure: hold `dig_ready`=0 for 20 cycles after `dig_valid` -> `digest` is stable and `blk_ready`=0 throughout; one cycle after `dig_ready`=1, state is IDLE and `blk_ready`=1.
- Timeout: stub core that never asserts `core_output_valid`, `TIMEOUT`=96 -> `err_timeout`=1 at launch+96 cycles, back in IDLE; the next `blk_first` block uses IV and clears `err_timeout`.
- Spurious `core_output_valid` pulsed in IDLE and DONE -> no change to `chain_reg`, `digest` or `blk_count`; a `blk_first`=0 block after a completed message launches with IV.
- Reset asserted 30 cycles into RUN -> all outputs at reset values immediately; a fresh "abc" block afterwards yields the correct digest.

Source files
------------

// File: rtl/sha256_seq_ctrl.sv
// Message-block sequencer for the iterative sha256 core: selects IV or the
// chained result per block, launches the core, and hands out the final digest.
module sha256_seq_ctrl #(
  parameter int unsigned TIMEOUT = 96
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [511:0] blk_data,
  input  logic         blk_first,
  input  logic         blk_last,
  output logic [255:0] core_H_in,
  output logic [511:0] core_M_in,
  output logic         core_input_valid,
  input  logic [255:0] core_H_out,
  input  logic         core_output_valid,
  output logic [255:0] digest,
  output logic         dig_valid,
  input  logic         dig_ready,
  output logic         busy,
  output logic         err_timeout,
  output logic [7:0]   blk_count
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_RUN    = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT);
  localparam logic [7:0] TMO_LAST  = 8'(TIMEOUT - 1);

  logic [1:0]   state;
  logic [511:0] m_reg;
  logic [255:0] h_sel_reg;
  logic [255:0] chain_reg;
  logic         last_reg;
  logic         chain_open;
  logic [7:0]   tmo_cnt;

  assign blk_ready        = (state == S_IDLE);
  assign core_input_valid = (state == S_LAUNCH);
  assign dig_valid        = (state == S_DONE);
  assign busy             = (state != S_IDLE);

  // The core re-adds H_in every cycle, so these must only change on block accept.
  assign core_H_in = h_sel_reg;
  assign core_M_in = m_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      m_reg       <= '0;
      h_sel_reg   <= '0;
      chain_reg   <= '0;
      last_reg    <= 1'b0;
      chain_open  <= 1'b0;
      tmo_cnt     <= '0;
      digest      <= '0;
      err_timeout <= 1'b0;
      blk_count   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (blk_valid) begin
            m_reg     <= blk_data;
            last_reg  <= blk_last;
            h_sel_reg <= (blk_first || !chain_open) ? IV : chain_reg;
            if (blk_first) begin
              err_timeout <= 1'b0;
              blk_count   <= '0;
            end
            state <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_cnt <= '0;
          state   <= S_RUN;
        end
        S_RUN: begin
          if (tmo_cnt != TMO_LIMIT) begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
          if (core_output_valid) begin
            chain_reg <= core_H_out;
            blk_count <= blk_count + 8'd1;
            if (last_reg) begin
              digest     <= core_H_out;
              chain_open <= 1'b0;
              state      <= S_DONE;
            end else begin
              chain_open <= 1'b1;
              state      <= S_IDLE;
            end
          end else if (tmo_cnt == TMO_LAST) begin
            // Counter would reach TIMEOUT this cycle: abandon the block and chain.
            err_timeout <= 1'b1;
            chain_open  <= 1'b0;
            blk_count   <= '0;
            state       <= S_IDLE;
          end
        end
        S_DONE: begin
          if (dig_ready) begin
            blk_count <= '0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_seq_ctrl.sv
// Directed bench for sha256_seq_ctrl; the bench itself plays the sha256 core
// and returns known SHA-256 chaining values.
module tb_sha256_seq_ctrl;

  localparam int unsigned TMO = 96;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;
  localparam logic [255:0] D_TWO =
    256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1;
  localparam logic [255:0] H1 =
    256'h85e655d6_417a1795_3363376a_624cde5c_76e09589_cac5f811_cc4b32c1_f20e533a;
  localparam logic [255:0] JUNK =
    256'hdeadbeef_cafef00d_01234567_89abcdef_fedcba98_76543210_a5a5a5a5_5a5a5a5a;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_last;
  logic [255:0] core_H_in;
  logic [511:0] core_M_in;
  logic         core_input_valid;
  logic [255:0] core_H_out;
  logic         core_output_valid;
  logic [255:0] digest;
  logic         dig_valid;
  logic         dig_ready;
  logic         busy;
  logic         err_timeout;
  logic [7:0]   blk_count;

  logic [511:0] blk_abc;
  logic [511:0] blk_m1;
  logic [511:0] blk_m2;

  int checks = 0;
  int passes = 0;
  int launch_cnt = 0;

  always #5 clk = ~clk;

  sha256_seq_ctrl #(.TIMEOUT(TMO)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .blk_valid        (blk_valid),
    .blk_ready        (blk_ready),
    .blk_data         (blk_data),
    .blk_first        (blk_first),
    .blk_last         (blk_last),
    .core_H_in        (core_H_in),
    .core_M_in        (core_M_in),
    .core_input_valid (core_input_valid),
    .core_H_out       (core_H_out),
    .core_output_valid(core_output_valid),
    .digest           (digest),
    .dig_valid        (dig_valid),
    .dig_ready        (dig_ready),
    .busy             (busy),
    .err_timeout      (err_timeout),
    .blk_count        (blk_count)
  );

  always @(posedge clk) begin
    if (rst_n && core_input_valid) launch_cnt = launch_cnt + 1;
  end

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Presents one block for a single cycle; returns in the LAUNCH cycle.
  task automatic send_block(input logic [511:0] d, input logic f, input logic l);
    blk_data  = d;
    blk_first = f;
    blk_last  = l;
    blk_valid = 1'b1;
    tick();
    blk_valid = 1'b0;
  endtask

  // Core answers after lat cycles; returns in the cycle after the result is sampled.
  task automatic core_done(input logic [255:0] h, input int lat);
    repeat (lat) tick();
    core_H_out        = h;
    core_output_valid = 1'b1;
    tick();
    core_output_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (core_input_valid !== 1'b0) $display("FAIL reset_civ: got %b want 0", core_input_valid); else passes++;
    checks++; if (dig_valid !== 1'b0) $display("FAIL reset_dig_valid: got %b want 0", dig_valid); else passes++;
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
    checks++; if (err_timeout !== 1'b0) $display("FAIL reset_err: got %b want 0", err_timeout); else passes++;
    checks++; if (blk_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", blk_count); else passes++;
    checks++; if (digest !== 256'd0) $display("FAIL reset_digest: got %h want 0", digest); else passes++;
    checks++; if (core_H_in !== 256'd0 || core_M_in !== 512'd0) $display("FAIL reset_core_in: got H=%h want 0", core_H_in); else passes++;
    rst_n = 1'b1;
    tick();
    checks++; if (blk_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", blk_ready); else passes++;
  endtask

  task automatic test_abc;
    int l0;
    l0 = launch_cnt;
    dig_ready = 1'b1;
    send_block(blk_abc, 1'b1, 1'b1);
    checks++; if (core_input_valid !== 1'b1) $display("FAIL abc_launch: got civ=%b want 1", core_input_valid); else passes++;
    checks++; if (core_H_in !== IV) $display("FAIL abc_h_in: got %h want %h", core_H_in, IV); else passes++;
    checks++; if (core_M_in !== blk_abc) $display("FAIL abc_m_in: got %h want %h", core_M_in, blk_abc); else passes++;
    tick();
    checks++; if (core_input_valid !== 1'b0 || busy !== 1'b1 || blk_ready !== 1'b0)
      $display("FAIL abc_run: got civ=%b busy=%b ready=%b want 0 1 0", core_input_valid, busy, blk_ready); else passes++;
    repeat (63) tick();
    core_H_out = D_ABC;
    core_output_valid = 1'b1;
    checks++; if (dig_valid !== 1'b0) $display("FAIL abc_dv_early: got %b want 0", dig_valid); else passes++;
    tick();
    core_output_valid = 1'b0;
    checks++; if (dig_valid !== 1'b1 || digest !== D_ABC) $display("FAIL abc_digest: got dv=%b %h want 1 %h", dig_valid, digest, D_ABC); else passes++;
    checks++; if (blk_count !== 8'd1) $display("FAIL abc_count: got %0d want 1", blk_count); else passes++;
    tick();
    checks++; if (blk_ready !== 1'b1 || dig_valid !== 1'b0 || blk_count !== 8'd0)
      $display("FAIL abc_idle: got ready=%b dv=%b count=%0d want 1 0 0", blk_ready, dig_valid, blk_count); else passes++;
    checks++; if (launch_cnt - l0 !== 1) $display("FAIL abc_launches: got %0d want 1", launch_cnt - l0); else passes++;
  endtask

  task automatic test_two_block;
    logic stable;
    dig_ready = 1'b1;
    send_block(blk_m1, 1'b1, 1'b0);
    checks++; if (core_H_in !== IV) $display("FAIL two_h1_in: got %h want %h", core_H_in, IV); else passes++;
    core_done(H1, 64);
    checks++; if (blk_ready !== 1'b1 || blk_count !== 8'd1 || dig_valid !== 1'b0)
      $display("FAIL two_mid: got ready=%b count=%0d dv=%b want 1 1 0", blk_ready, blk_count, dig_valid); else passes++;
    send_block(blk_m2, 1'b0, 1'b1);
    checks++; if (core_H_in !== H1) $display("FAIL two_chain: got %h want %h", core_H_in, H1); else passes++;
    stable = 1'b1;
    repeat (20) begin
      tick();
      if (core_H_in !== H1 || core_M_in !== blk_m2) stable = 1'b0;
    end
    checks++; if (stable !== 1'b1) $display("FAIL two_stable: got %b want 1", stable); else passes++;
    core_done(D_TWO, 30);
    checks++; if (dig_valid !== 1'b1 || digest !== D_TWO) $display("FAIL two_digest: got dv=%b %h want 1 %h", dig_valid, digest, D_TWO); else passes++;
    checks++; if (blk_count !== 8'd2) $display("FAIL two_count: got %0d want 2", blk_count); else passes++;
    tick();
  endtask

  task automatic test_backpressure;
    logic ok;
    int l0;
    dig_ready = 1'b0;
    send_block(blk_abc, 1'b1, 1'b1);
    core_done(D_ABC, 64);
    l0 = launch_cnt;
    ok = 1'b1;
    blk_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (dig_valid !== 1'b1 || digest !== D_ABC || blk_ready !== 1'b0) ok = 1'b0;
      tick();
    end
    blk_valid = 1'b0;
    checks++; if (ok !== 1'b1) $display("FAIL bp_hold: got %b want 1", ok); else passes++;
    checks++; if (launch_cnt !== l0) $display("FAIL bp_no_accept: got %0d launches want 0", launch_cnt - l0); else passes++;
    dig_ready = 1'b1;
    tick();
    checks++; if (busy !== 1'b0 || blk_ready !== 1'b1 || dig_valid !== 1'b0)
      $display("FAIL bp_release: got busy=%b ready=%b dv=%b want 0 1 0", busy, blk_ready, dig_valid); else passes++;
  endtask

  task automatic test_spurious;
    dig_ready = 1'b1;
    core_H_out = JUNK;
    core_output_valid = 1'b1;
    tick();
    core_output_valid = 1'b0;
    checks++; if (busy !== 1'b0 || blk_count !== 8'd0 || dig_valid !== 1'b0)
      $display("FAIL sp_idle0: got busy=%b count=%0d dv=%b want 0 0 0", busy, blk_count, dig_valid); else passes++;
    send_block(blk_m1, 1'b1, 1'b0);
    core_done(H1, 10);
    core_H_out = JUNK;
    core_output_valid = 1'b1;
    tick();
    core_output_valid = 1'b0;
    checks++; if (blk_count !== 8'd1) $display("FAIL sp_idle_count: got %0d want 1", blk_count); else passes++;
    dig_ready = 1'b0;
    send_block(blk_m2, 1'b0, 1'b1);
    checks++; if (core_H_in !== H1) $display("FAIL sp_chain: got %h want %h", core_H_in, H1); else passes++;
    core_done(D_TWO, 10);
    core_H_out = JUNK;
    core_output_valid = 1'b1;
    tick();
    core_output_valid = 1'b0;
    checks++; if (digest !== D_TWO || blk_count !== 8'd2 || dig_valid !== 1'b1)
      $display("FAIL sp_done: got %h count=%0d dv=%b want %h 2 1", digest, blk_count, dig_valid, D_TWO); else passes++;
    dig_ready = 1'b1;
    tick();
    send_block(blk_abc, 1'b0, 1'b1);
    checks++; if (core_H_in !== IV) $display("FAIL sp_closed_iv: got %h want %h", core_H_in, IV); else passes++;
    core_H_out = JUNK;
    core_output_valid = 1'b1;
    tick();
    core_output_valid = 1'b0;
    checks++; if (busy !== 1'b1 || dig_valid !== 1'b0) $display("FAIL sp_launch: got busy=%b dv=%b want 1 0", busy, dig_valid); else passes++;
    core_done(D_ABC, 10);
    checks++; if (digest !== D_ABC) $display("FAIL sp_final: got %h want %h", digest, D_ABC); else passes++;
    tick();
  endtask

  task automatic test_timeout;
    dig_ready = 1'b1;
    send_block(blk_abc, 1'b1, 1'b1);
    repeat (TMO - 1) tick();
    checks++; if (err_timeout !== 1'b0 || busy !== 1'b1) $display("FAIL tmo_early: got err=%b busy=%b want 0 1", err_timeout, busy); else passes++;
    repeat (2) tick();
    checks++; if (err_timeout !== 1'b1) $display("FAIL tmo_flag: got %b want 1", err_timeout); else passes++;
    checks++; if (busy !== 1'b0 || blk_ready !== 1'b1 || blk_count !== 8'd0)
      $display("FAIL tmo_idle: got busy=%b ready=%b count=%0d want 0 1 0", busy, blk_ready, blk_count); else passes++;
    send_block(blk_m1, 1'b0, 1'b0);
    checks++; if (core_H_in !== IV) $display("FAIL tmo_iv: got %h want %h", core_H_in, IV); else passes++;
    core_done(H1, 10);
    checks++; if (err_timeout !== 1'b1 || blk_count !== 8'd1) $display("FAIL tmo_sticky: got err=%b count=%0d want 1 1", err_timeout, blk_count); else passes++;
    send_block(blk_abc, 1'b1, 1'b1);
    checks++; if (core_H_in !== IV || err_timeout !== 1'b0)
      $display("FAIL tmo_restart: got H=%h err=%b want %h 0", core_H_in, err_timeout, IV); else passes++;
    core_done(D_ABC, 10);
    checks++; if (digest !== D_ABC) $display("FAIL tmo_digest: got %h want %h", digest, D_ABC); else passes++;
    tick();
  endtask

  task automatic test_reset_mid_run;
    int l0;
    dig_ready = 1'b1;
    send_block(blk_m1, 1'b1, 1'b0);
    core_done(H1, 10);
    send_block(blk_m2, 1'b0, 1'b1);
    repeat (31) tick();
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || core_input_valid !== 1'b0 || dig_valid !== 1'b0)
      $display("FAIL rst_ctrl: got busy=%b civ=%b dv=%b want 0 0 0", busy, core_input_valid, dig_valid); else passes++;
    checks++; if (blk_count !== 8'd0 || err_timeout !== 1'b0) $display("FAIL rst_count: got %0d err=%b want 0 0", blk_count, err_timeout); else passes++;
    checks++; if (core_H_in !== 256'd0 || core_M_in !== 512'd0 || digest !== 256'd0)
      $display("FAIL rst_data: got H=%h dig=%h want 0 0", core_H_in, digest); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    l0 = launch_cnt;
    repeat (5) tick();
    checks++; if (launch_cnt !== l0 || busy !== 1'b0) $display("FAIL rst_no_relaunch: got %0d launches busy=%b want 0 0", launch_cnt - l0, busy); else passes++;
    send_block(blk_abc, 1'b0, 1'b1);
    checks++; if (core_H_in !== IV) $display("FAIL rst_iv: got %h want %h", core_H_in, IV); else passes++;
    core_done(D_ABC, 64);
    checks++; if (dig_valid !== 1'b1 || digest !== D_ABC) $display("FAIL rst_digest: got dv=%b %h want 1 %h", dig_valid, digest, D_ABC); else passes++;
    tick();
  endtask

  initial begin
    blk_valid = 1'b0;
    blk_data = '0;
    blk_first = 1'b0;
    blk_last = 1'b0;
    core_H_out = '0;
    core_output_valid = 1'b0;
    dig_ready = 1'b0;
    blk_abc = '0;
    blk_abc[511:480] = 32'h61626380;
    blk_abc[31:0] = 32'h00000018;
    blk_m1 = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    blk_m2 = '0;
    blk_m2[31:0] = 32'h000001c0;
    test_reset();
    test_abc();
    test_two_block();
    test_backpressure();
    test_spurious();
    test_timeout();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", passes, checks);
    $fatal(1);
  end

endmodule
